// File: rtl/mult4_seq_ctrl.sv
// Shift-and-add unsigned multiply sequencer driving an external combinational adder.
// Optional MULT_ZERO_SKIP_EN: zero operands bypass CALC and complete in one edge.
module mult4_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic               as_add_sub,
    output logic [WIDTH-1:0]   as_a,
    output logic [WIDTH-1:0]   as_b,
    input  logic [WIDTH-1:0]   as_r,
    input  logic               as_co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   m, m_nx;
    logic [WIDTH-1:0]   q, q_nx;
    logic [WIDTH-1:0]   acc, acc_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [2*WIDTH-1:0] p_nx;
    logic               done_nx;
    logic [2*WIDTH-1:0] shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            m     <= m_nx;
            q     <= q_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            p     <= p_nx;
            done  <= done_nx;
        end
    end

    // {carry, sum, Q} shifted right by one; Q[0] has already been consumed
    assign shifted = {as_co, as_r, q[WIDTH-1:1]};

    always_comb begin
        state_nx   = state;
        m_nx       = m;
        q_nx       = q;
        acc_nx     = acc;
        cnt_nx     = cnt;
        p_nx       = p;
        done_nx    = 1'b0;
        busy       = 1'b0;
        as_add_sub = 1'b0;
        as_a       = '0;
        as_b       = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    m_nx   = a;
                    q_nx   = b;
                    acc_nx = '0;
                    cnt_nx = '0;
`ifdef MULT_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        p_nx     = '0;
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = CALC;
                    end
`else
                    state_nx = CALC;
`endif
                end
            end
            CALC: begin
                busy   = 1'b1;
                as_a   = acc;
                as_b   = q[0] ? m : '0;
                acc_nx = shifted[2*WIDTH-1:WIDTH];
                q_nx   = shifted[WIDTH-1:0];
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    p_nx     = shifted;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Scoreboard bench for mult4_seq_ctrl with a behavioural adder and a*b reference.
// Directed cases from the block description plus randomized operand pairs.
module tb_mult4_seq_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a, b;
    logic           busy, done;
    logic [2*W-1:0] p;
    logic           as_add_sub;
    logic [W-1:0]   as_a, as_b, as_r;
    logic           as_co;

    always #5 clk = ~clk;

    // external combinational adder/subtractor
    assign {as_co, as_r} = as_add_sub ? ({1'b0, as_a} - {1'b0, as_b})
                                      : ({1'b0, as_a} + {1'b0, as_b});

    mult4_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .p(p),
        .as_add_sub(as_add_sub),
        .as_a(as_a),
        .as_b(as_b),
        .as_r(as_r),
        .as_co(as_co)
    );

    int checks = 0;
    int errors = 0;
    int exp_p[$];
    int exp_busy[$];
    int exp_carry[$];

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=done", name);
    endtask

    function automatic int busy_for(int x, int y);
`ifdef MULT_ZERO_SKIP_EN
        return (x == 0 || y == 0) ? 0 : W;
`else
        return W;
`endif
    endfunction

    // monitor: pops expectations whenever done is presented
    int             busy_cnt  = 0;
    int             carry_cnt = 0;
    logic           prev_done = 1'b0;
    logic [2*W-1:0] last_p    = '0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt  = 0;
            carry_cnt = 0;
            prev_done = 1'b0;
            last_p    = '0;
        end else begin
            check("add_sub_mode", int'(as_add_sub), 0);
            if (!busy)
                check("adder_idle", int'({as_a, as_b}), 0);
            if (busy) begin
                busy_cnt++;
                if (as_co) carry_cnt++;
            end
            if (done) begin
                int ep, eb, ec;
                check("done_width", int'(prev_done), 0);
                check("done_expected", int'(exp_p.size() > 0), 1);
                if (exp_p.size() > 0) begin
                    ep = exp_p.pop_front();
                    eb = exp_busy.pop_front();
                    ec = exp_carry.pop_front();
                    check("product", int'(p), ep);
                    check("busy_cycles", busy_cnt, eb);
                    if (ec >= 0) check("carry_cycles", carry_cnt, ec);
                end
                last_p    = p;
                busy_cnt  = 0;
                carry_cnt = 0;
            end else begin
                check("p_held", int'(p), int'(last_p));
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("wait_idle");
    endtask

    task automatic wait_done(string name, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) timeout(name);
    endtask

    task automatic run_op(int x, int y, int carries = -1);
        int lat;
        wait_idle();
        a     = x[W-1:0];
        b     = y[W-1:0];
        start = 1'b1;
        exp_p.push_back(x * y);
        exp_busy.push_back(busy_for(x, y));
        exp_carry.push_back(carries);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done("op_done", lat);
        if (done) check("latency", lat, busy_for(x, y));
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_p", int'(p), 0);
        check("rst_adder", int'({as_add_sub, as_a, as_b}), 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(13, 11);
        run_op(15, 15, 3);
        run_op(0, 7);

        // start held high across CALC/DONE with new operands
        wait_idle();
        a     = 4'd9;
        b     = 4'd6;
        start = 1'b1;
        exp_p.push_back(54);
        exp_busy.push_back(busy_for(9, 6));
        exp_carry.push_back(-1);
        @(negedge clk);
        a = 4'd3;
        b = 4'd3;
        exp_p.push_back(9);
        exp_busy.push_back(busy_for(3, 3));
        exp_carry.push_back(-1);
        wait_done("held_first", lat);
        @(negedge clk);
        check("held_ignored_in_done", int'(busy), 0);
        @(negedge clk);
        check("held_accepted_idle", int'(busy), 1);
        start = 1'b0;
        wait_done("held_second", lat);

        // reset mid-CALC aborts without a done pulse
        wait_idle();
        a     = 4'd7;
        b     = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_p", int'(p), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(7, 5);

        run_op(2, 3);
        run_op(15, 1);

        for (int i = 0; i < 24; i++)
            run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        run_op(0, 0);
        run_op(15, 0);

        for (int n = 0; n < 20 && exp_p.size() > 0; n++)
            @(negedge clk);
        check("scoreboard_drained", exp_p.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
